// File: rtl/if_id_fetch_queue_if.sv
// Fetch-queue bus: fetch control, imem request/response and ID-side ports.
// master = fetch queue, slave = surrounding pipeline/memory.
interface if_id_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pc_write;
  logic          PCSrc;
  logic [31:0]   PC_Branch;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          id_valid;
  logic          id_ready;
  logic [31:0]   PC_ID;
  logic [31:0]   INSTRUCTION_ID;
  logic [CW-1:0] count;
  logic          rsp_err;

  modport master (
    input  pc_write, PCSrc, PC_Branch,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_ready,
    output imem_req_valid, imem_req_addr,
    output id_valid, PC_ID, INSTRUCTION_ID,
    output count, rsp_err
  );

  modport slave (
    output pc_write, PCSrc, PC_Branch,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_ready,
    input  imem_req_valid, imem_req_addr,
    input  id_valid, PC_ID, INSTRUCTION_ID,
    input  count, rsp_err
  );
endinterface

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: PC generation, credit-limited imem requests,
// in-flight PC tracking and an in-order instruction queue toward ID.
module if_id_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  reset,
  if_id_fetch_queue_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] qwr_q, qwr_d;
  logic [AW-1:0] qrd_q, qrd_d;
  logic [AW-1:0] fwr_q, fwr_d;
  logic [AW-1:0] frd_q, frd_d;
  logic          err_q, err_d;

  logic [31:0] qpc_mem  [DEPTH];
  logic [31:0] qins_mem [DEPTH];
  logic [31:0] fpc_mem  [DEPTH];

  logic        flush;
  logic        req_v;
  logic        req_hs;
  logic        deq;
  logic        rsp_ok;
  logic        drop;
  logic        enq;
  logic        has_head;
  logic [CW:0] credit;
  logic        unused_br;

  assign unused_br = ^bus.PC_Branch[1:0];

  assign flush    = bus.PCSrc;
  assign has_head = (count_q != '0);
  assign credit   = {1'b0, count_q} + {1'b0, out_q};

  // Outstanding requests reserve queue slots, so responses never stall.
  assign req_v  = reset & bus.pc_write & ~flush
                & (credit < DEPTH_W);
  assign req_hs = req_v & bus.imem_req_ready;
  assign deq    = has_head & ~flush & bus.id_ready;
  assign rsp_ok = bus.imem_rsp_valid & (out_q != '0);
  assign drop   = rsp_ok & (drop_q != '0);
  assign enq    = rsp_ok & (drop_q == '0) & ~flush;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q + CW'(enq) - CW'(deq);
    out_d   = out_q + CW'(req_hs) - CW'(rsp_ok);
    drop_d  = drop_q;
    qwr_d   = qwr_q + AW'(enq);
    qrd_d   = qrd_q + AW'(deq);
    fwr_d   = fwr_q + AW'(req_hs);
    frd_d   = frd_q + AW'(enq);
    err_d   = err_q | (bus.imem_rsp_valid & (out_q == '0));
    if (drop) begin
      drop_d = drop_q - 1'b1;
    end
    if (req_hs) begin
      pc_d = pc_q + 32'd4;
    end
    // Every request still in flight at a redirect is wrong-path.
    if (flush) begin
      pc_d    = {bus.PC_Branch[31:2], 2'b00};
      count_d = '0;
      drop_d  = out_q - CW'(rsp_ok);
      qwr_d   = '0;
      qrd_d   = '0;
      fwr_d   = '0;
      frd_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      out_q   <= '0;
      drop_q  <= '0;
      qwr_q   <= '0;
      qrd_q   <= '0;
      fwr_q   <= '0;
      frd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      qwr_q   <= qwr_d;
      qrd_q   <= qrd_d;
      fwr_q   <= fwr_d;
      frd_q   <= frd_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs) begin
      fpc_mem[fwr_q] <= pc_q;
    end
    if (enq) begin
      qpc_mem[qwr_q]  <= fpc_mem[frd_q];
      qins_mem[qwr_q] <= bus.imem_rsp_data;
    end
  end

  assign bus.imem_req_valid = req_v;
  assign bus.imem_req_addr  = pc_q;
  assign bus.id_valid       = has_head & ~flush;
  assign bus.PC_ID          = has_head ? qpc_mem[qrd_q]  : 32'h0;
  assign bus.INSTRUCTION_ID = has_head ? qins_mem[qrd_q] : 32'h0;
  assign bus.count          = count_q;
  assign bus.rsp_err        = err_q;
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Randomized bench for if_id_fetch_queue against a queue-based
// transaction model of fetch, redirect and drop behaviour.
module tb_if_id_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  typedef struct packed {
    logic [31:0] pc;
    logic        dead;
  } fl_t;
  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mr_t;

  logic clk;
  logic reset;
  if_id_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  if_id_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        rst_v, pw, fl, idr, rdy, spur;
  logic [31:0] br;
  int          lat_lo, lat_hi, last_due;
  logic        from_mem, hs;
  logic [31:0] hs_addr;

  ent_t idq[$];
  fl_t  inflight[$];
  mr_t  mem[$];
  logic [31:0] mpc;
  logic        m_err, m_rv, m_iv;
  logic [101:0] expv;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  function automatic logic [101:0] obs();
    return {bus.imem_req_valid, bus.imem_req_addr, bus.id_valid,
            bus.PC_ID, bus.INSTRUCTION_ID, bus.count, bus.rsp_err};
  endfunction

  function automatic void model_reset();
    idq.delete();
    inflight.delete();
    mpc   = RESET_PC;
    m_err = 1'b0;
  endfunction

  function automatic void calc_exp();
    logic [31:0] hp, hi;
    m_rv = reset & pw & ~fl & ((idq.size() + inflight.size()) < DEPTH);
    m_iv = (idq.size() != 0) & ~fl;
    hp = 32'h0;
    hi = 32'h0;
    if (idq.size() != 0) begin
      hp = idq[0].pc;
      hi = idq[0].ins;
    end
    expv = {m_rv, mpc, m_iv, hp, hi, 3'(idq.size()), m_err};
  endfunction

  task automatic drive();
    @(negedge clk);
    reset              = rst_v;
    bus.pc_write       = pw;
    bus.PCSrc          = fl;
    bus.PC_Branch      = br;
    bus.id_ready       = idr;
    bus.imem_req_ready = rdy;
    from_mem = (mem.size() != 0) && (mem[0].due == cyc);
    bus.imem_rsp_valid = from_mem | spur;
    bus.imem_rsp_data  = from_mem ? memfn(mem[0].addr) : $urandom;
    #1;
    calc_exp();
    hs      = bus.imem_req_valid & rdy;
    hs_addr = bus.imem_req_addr;
  endtask

  task automatic tick();
    ent_t e;
    fl_t  f;
    mr_t  m;
    logic got;
    int   d;
    @(posedge clk);
    got = 1'b0;
    e   = '0;
    if (reset) begin
      if (bus.imem_rsp_valid) begin
        if (inflight.size() == 0) begin
          m_err = 1'b1;
        end else begin
          f = inflight.pop_front();
          if (!f.dead && !fl) begin
            e.pc  = f.pc;
            e.ins = memfn(f.pc);
            got   = 1'b1;
          end
        end
      end
      if (m_iv && idr) void'(idq.pop_front());
      if (got) idq.push_back(e);
      if (fl) begin
        idq.delete();
        foreach (inflight[i]) inflight[i].dead = 1'b1;
        mpc = {br[31:2], 2'b00};
      end
      if (m_rv && rdy) begin
        f.pc   = mpc;
        f.dead = 1'b0;
        inflight.push_back(f);
        mpc = mpc + 32'd4;
      end
    end
    if (from_mem) void'(mem.pop_front());
    if (hs) begin
      d = cyc + $urandom_range(lat_lo, lat_hi);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      m.addr   = hs_addr;
      m.due    = d;
      mem.push_back(m);
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst_v = 1'b0; pw = 1'b1; fl = 1'b0; idr = 1'b1; rdy = 1'b1;
    spur = 1'b0; br = 32'h0; lat_lo = 1; lat_hi = 1;
    model_reset();
    drive();
    total++;
    if (obs() !== expv)
      $display("FAIL reset got=%h exp=%h", obs(), expv);
    if (obs() !== expv) bad++;
    tick();
    rst_v = 1'b1;
  endtask

  task automatic test_stream();
    int nv = 0;
    pw = 1'b1; idr = 1'b1; rdy = 1'b1; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20; i++) begin
      drive();
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL stream c=%0d got=%h exp=%h", cyc, obs(), expv);
      end
      if (i >= 3 && bus.id_valid) nv++;
      tick();
    end
    total++;
    if (nv !== 17) begin
      bad++;
      $display("FAIL stream_rate got=%0d exp=17", nv);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] seen;
    idr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive();
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL bp_hold c=%0d got=%h exp=%h", cyc, obs(), expv);
      end
      seen = {bus.count, bus.imem_req_valid};
      tick();
    end
    total++;
    if (seen !== 4'b1000) begin
      bad++;
      $display("FAIL bp_full got=%b exp=1000", seen);
    end
    idr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive();
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL bp_resume c=%0d got=%h exp=%h", cyc, obs(), expv);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] a0, a1;
    pw = 1'b0; idr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive();
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL stall c=%0d got=%h exp=%h", cyc, obs(), expv);
      end
      if (i == 0) a0 = bus.imem_req_addr;
      a1 = bus.imem_req_addr;
      tick();
    end
    drive();
    total++;
    if ({a1, bus.count} !== {a0, 3'd0}) begin
      bad++;
      $display("FAIL stall_drain got=%h/%0d exp=%h/0", a1, bus.count, a0);
    end
    tick();
    pw = 1'b1;
  endtask

  task automatic test_flush();
    logic found = 1'b0;
    logic post  = 1'b0;
    logic chk   = 1'b0;
    lat_lo = 3; lat_hi = 3; idr = 1'b1; pw = 1'b1; br = 32'h100;
    for (int i = 0; i < 30; i++) begin
      fl = !found && (inflight.size() == 3);
      drive();
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL flush c=%0d got=%h exp=%h", cyc, obs(), expv);
      end
      if (post && !chk && bus.id_valid) begin
        chk = 1'b1;
        total++;
        if (bus.PC_ID !== 32'h100) begin
          bad++;
          $display("FAIL flush_target got=%h exp=00000100", bus.PC_ID);
        end
      end
      tick();
      if (found) post = 1'b1;
      if (fl) found = 1'b1;
      fl = 1'b0;
    end
    total++;
    if (!chk) begin
      bad++;
      $display("FAIL flush_timeout got=none exp=PC_ID 0x100");
    end
    br = 32'hFFFF_FFF7;
    for (int i = 0; i < 12; i++) begin
      fl = (i == 0);
      drive();
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL wrap c=%0d got=%h exp=%h", cyc, obs(), expv);
      end
      tick();
    end
    fl = 1'b0;
  endtask

  task automatic test_flush_full();
    logic done = 1'b0;
    lat_lo = 3; lat_hi = 3; br = 32'h0;
    for (int i = 0; i < 8; i++) begin
      fl = (i == 0); pw = 1'b0; idr = 1'b1;
      drive();
      tick();
    end
    fl = 1'b0; pw = 1'b1; idr = 1'b0; br = 32'h40;
    for (int i = 0; i < 30 && !done; i++) begin
      fl = (idq.size() == 3) && (inflight.size() == 1)
        && (mem.size() != 0) && (mem[0].due == cyc);
      drive();
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL ffull c=%0d got=%h exp=%h", cyc, obs(), expv);
      end
      tick();
      done = fl;
    end
    fl = 1'b0;
    drive();
    total++;
    if ({done, bus.count} !== {1'b1, 3'd0}) begin
      bad++;
      $display("FAIL ffull_cnt got=%b/%0d exp=1/0", done, bus.count);
    end
    tick();
    idr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive();
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL ffull_after c=%0d got=%h exp=%h", cyc, obs(), expv);
      end
      tick();
    end
    total++;
    if (bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL ffull_err got=%b exp=0", bus.rsp_err);
    end
  endtask

  task automatic test_random();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 400; i++) begin
      pw  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 3) != 0);
      idr = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      br  = $urandom;
      drive();
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL random c=%0d got=%h exp=%h", cyc, obs(), expv);
      end
      tick();
    end
    fl = 1'b0; rdy = 1'b1; idr = 1'b1; pw = 1'b1;
  endtask

  task automatic test_reset_mid();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 6; i++) begin
      drive();
      tick();
    end
    drive();
    #1 reset = 1'b0;
    rst_v = 1'b0;
    hs    = 1'b0;
    #1;
    model_reset();
    calc_exp();
    total++;
    if (obs() !== expv) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", obs(), expv);
    end
    tick();
    rst_v = 1'b1; pw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive();
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL post_reset c=%0d got=%h exp=%h", cyc, obs(), expv);
      end
      tick();
    end
    total++;
    if (bus.rsp_err !== 1'b1) begin
      bad++;
      $display("FAIL spurious_err got=%b exp=1", bus.rsp_err);
    end
  endtask

  initial begin
    reset = 1'b0;
    last_due = -1;
    bus.pc_write = 1'b0;
    bus.PCSrc = 1'b0;
    bus.PC_Branch = 32'h0;
    bus.id_ready = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_flush_full();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
